slice_config_loader: RTL and testbench
======================================

# slice_config_loader

Configuration-load front end for the fracturable-LUT carry slice. It accepts a word-serial bitstream over a valid/ready handshake and assembles it into a shadow register holding every LUT configuration plus the carry-chain enable. Once the image is complete, it pulses `cen` for exactly one `cclk` cycle so the slice commits the image. It sits directly upstream of the slice's `luts_config_in`/`config_use_cc`/`cen` inputs, in the `cclk` domain.

## Interface
Parameters:
- `S_XX_BASE`, 4, base LUT input count; `CFG_SIZE = 2**S_XX_BASE+1` (17).
- `NUM_LUTS`, 4, LUTs per slice; each LUT takes `2*CFG_SIZE` (34) config bits.
- `WORD_W`, 8, bitstream word width.
- Derived: `TOTAL = NUM_LUTS*2*CFG_SIZE+1` (137), `NWORDS = ceil(TOTAL/WORD_W)` (18), `PAD = NWORDS*WORD_W-TOTAL` (7).

Ports:
- `cclk`  in  1  configuration clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a load; honoured only in IDLE or DONE.
- `in_data`  in  WORD_W  bitstream word.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader accepts a word this cycle.
- `luts_config_out`  out  NUM_LUTS*2*CFG_SIZE  flattened LUT config; LUT i at `[i*2*CFG_SIZE +: 2*CFG_SIZE]`.
- `config_use_cc`  out  1  carry-chain enable bit.
- `cen`  out  1  commit strobe to the slice, one cycle.
- `busy`  out  1  high in LOAD or COMMIT.
- `done`  out  1  high in DONE, a level signal.

## Operation
- Shadow register `sh`, `NWORDS*WORD_W` bits wide. On each accepted word: `sh <= {sh[NWORDS*WORD_W-WORD_W-1:0], in_data}`. The first word lands in the highest bits.
- Mapping after a full load:
  - `config_use_cc = sh[0]`.
  - `luts_config_out = sh[TOTAL-1:1]`.
  - The top PAD bits of `sh` are the upper PAD bits of word 0. They are ignored.
- Word counter `wcnt`: 0..NWORDS-1, 5 bits at defaults. It clears on entry to LOAD and increments per accepted word.
- States:
  - IDLE: `in_ready=0`. `start` → LOAD.
  - LOAD: `in_ready=1`. A transfer occurs when `in_valid & in_ready` at the rising edge. On the transfer where `wcnt==NWORDS-1`, go to COMMIT. `start` is ignored.
  - COMMIT: `cen=1`, `in_ready=0`. Unconditionally → DONE next cycle.
  - DONE: `done=1`, `in_ready=0`. `start` → LOAD, clearing `wcnt`. Outputs hold the last image.
- `in_ready` is a combinational decode of state (`state==LOAD`). It does not depend on `in_valid`.
- `sh`, `luts_config_out` and `config_use_cc` drive straight from `sh`. They change during LOAD, but are stable throughout the COMMIT cycle, so the slice latches a consistent image.
- Reset values:
  - state IDLE, `wcnt=0`, `sh=0`.
  - `in_ready`, `cen`, `busy` and `done` all 0.
  - `luts_config_out=0`, `config_use_cc=0`.
- Reset mid-load discards the partial image. `cen` does not pulse. Reset asserted in the COMMIT cycle forces `cen=0` from the next cycle; the current cycle's strobe is not extended.
- Words offered while `in_ready=0` are neither consumed nor shifted.

## Timing
- `start` sampled at edge E: LOAD from E+1. `in_ready` rises in the cycle after E.
- Back-to-back valid: words are accepted on edges E+1 .. E+NWORDS.
  - COMMIT (`cen=1`) is cycle E+NWORDS .. E+NWORDS+1.
  - `done` rises at edge E+NWORDS+1.
- Minimum start-to-`cen` latency is NWORDS+1 edges (19 at defaults). Each valid-low cycle in LOAD adds one cycle.
- `cen` is high for exactly one cycle per completed load. It is never asserted without NWORDS accepted words since the last entry to LOAD.
- `in_ready` deasserts in the cycle after the final word is accepted. A word held valid then is not taken.

## Test plan
- Reset: assert `rst` for 2 cycles with `in_valid=1` and `start=1` → all outputs 0, state IDLE, no `cen`.
- Full load at defaults with words 0x00..0x11 and valid held high:
  - `cen` is high exactly once, 19 cycles after `start`.
  - `config_use_cc = 0x11[0] = 1`.
  - `luts_config_out` equals bits [136:1] of the concatenation 0x00..0x11.
  - `done` is high the next cycle.
- Backpressure: the same stream with `in_valid` toggling 1/0 → identical final image, `cen` at cycle 37, exactly 18 transfers counted.
- Mid-load reset: assert `rst` after 10 words, then `start` and 18 fresh words → `cen` fires once, with an image built only from the fresh words.
- `start` pulsed during LOAD at word 5 → ignored; the load completes after 18 total words.
- Reload from DONE with an all-ones stream → second `cen` pulse; `luts_config_out` is all ones and `config_use_cc=1`. An extra word offered in DONE is not accepted (`in_ready=0`).

Source files
------------

// File: rtl/slice_config_loader.sv
// Word-serial configuration loader for the fracturable-LUT carry slice: shifts a
// bitstream into a shadow register and strobes cen once per complete image.
module slice_config_loader #(
    parameter int S_XX_BASE = 4,
    parameter int NUM_LUTS  = 4,
    parameter int WORD_W    = 8
) (
    input  logic                                        cclk,
    input  logic                                        rst,
    input  logic                                        start,
    input  logic [WORD_W-1:0]                           in_data,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    output logic [NUM_LUTS*2*(2**S_XX_BASE+1)-1:0]      luts_config_out,
    output logic                                        config_use_cc,
    output logic                                        cen,
    output logic                                        busy,
    output logic                                        done
);

    localparam int CFG_SIZE = 2**S_XX_BASE + 1;
    localparam int TOTAL    = NUM_LUTS*2*CFG_SIZE + 1;
    localparam int NWORDS   = (TOTAL + WORD_W - 1) / WORD_W;
    localparam int SH_W     = NWORDS*WORD_W;
    localparam int CNT_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CNT_W-1:0]   wcnt_r;
    logic [SH_W-1:0]    sh_r;
    logic               xfer_s;
    logic               last_word_s;
    logic               load_entry_s;

    assign xfer_s       = in_valid && (state_r == LOAD);
    assign last_word_s  = (wcnt_r == CNT_W'(NWORDS-1));
    assign load_entry_s = start && ((state_r == IDLE) || (state_r == DONE));

    // Next-state decode; start is only honoured outside LOAD/COMMIT.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD: begin
                if (xfer_s && last_word_s) begin
                    state_nxt_s = COMMIT;
                end else begin
                    state_nxt_s = LOAD;
                end
            end
            COMMIT: state_nxt_s = DONE;
            DONE: begin
                if (start) begin
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge cclk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Word counter: restarts on every entry to LOAD, advances per accepted word.
    always_ff @(posedge cclk) begin
        if (rst) begin
            wcnt_r <= '0;
        end else if (load_entry_s) begin
            wcnt_r <= '0;
        end else if (xfer_s) begin
            wcnt_r <= wcnt_r + CNT_W'(1);
        end else begin
            wcnt_r <= wcnt_r;
        end
    end

    // Shadow register: first word ends up in the most significant bits.
    always_ff @(posedge cclk) begin
        if (rst) begin
            sh_r <= '0;
        end else if (xfer_s) begin
            sh_r <= {sh_r[SH_W-WORD_W-1:0], in_data};
        end else begin
            sh_r <= sh_r;
        end
    end

    // Status and strobe decode straight from the state register (glitch-free).
    always_comb begin
        in_ready = 1'b0;
        cen      = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_r)
            IDLE:    begin end
            LOAD:    begin in_ready = 1'b1; busy = 1'b1; end
            COMMIT:  begin cen = 1'b1; busy = 1'b1; end
            DONE:    begin done = 1'b1; end
            default: begin end
        endcase
    end

    // The upper pad bits of word 0 are dropped here.
    assign config_use_cc   = sh_r[0];
    assign luts_config_out = sh_r[TOTAL-1:1];

endmodule

// File: tb/tb_slice_config_loader.sv
// Directed self-checking bench for slice_config_loader at default parameters.
module tb_slice_config_loader;

    logic          cclk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [135:0]  luts_config_out;
    logic          config_use_cc;
    logic          cen;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;

    logic [7:0]    words [18];
    logic [143:0]  exp_sh;
    logic [135:0]  exp_luts;
    int            lat, xfers, cens;
    logic [135:0]  commit_luts;
    logic          commit_cc;

    always #5 cclk = ~cclk;

    slice_config_loader dut (
        .cclk            (cclk),
        .rst             (rst),
        .start           (start),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .luts_config_out (luts_config_out),
        .config_use_cc   (config_use_cc),
        .cen             (cen),
        .busy            (busy),
        .done            (done)
    );

    task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge cclk);
        #1;
    endtask

    // Runs one load from IDLE/DONE. lat counts edges from the start-sampling
    // edge to the edge that raises cen, inclusive.
    task automatic do_load(input bit toggle, input bit start_at5,
                           output int lat_o, output int xfers_o, output int cens_o);
        int  idx;
        int  n;
        bit  phase;
        bit  pulsed;
        bit  xfer;
        idx = 0; n = 0; phase = 1'b0; pulsed = 1'b0;
        lat_o = 0; xfers_o = 0; cens_o = 0;
        start = 1'b1; in_valid = 1'b0;
        tick();
        n = 1;
        start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            in_valid = toggle ? phase : 1'b1;
            phase    = ~phase;
            in_data  = (idx < 18) ? words[idx] : 8'hEE;
            if (start_at5 && idx == 5 && !pulsed) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
            xfer = in_valid && in_ready;
            tick();
            n++;
            if (xfer) begin
                idx++;
                xfers_o++;
            end
            if (cen) begin
                cens_o++;
                if (cens_o == 1) begin
                    lat_o       = n;
                    commit_luts = luts_config_out;
                    commit_cc   = config_use_cc;
                end
            end
            if (done) break;
        end
        start = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
        commit_luts = '0; commit_cc = 1'b0;

        // Reset with start and valid asserted.
        tick();
        tick();
        chk("rst_in_ready", {135'd0, in_ready}, 136'd0);
        chk("rst_cen", {135'd0, cen}, 136'd0);
        chk("rst_busy", {135'd0, busy}, 136'd0);
        chk("rst_done", {135'd0, done}, 136'd0);
        chk("rst_luts", luts_config_out, 136'd0);
        chk("rst_cc", {135'd0, config_use_cc}, 136'd0);
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        tick();
        chk("idle_in_ready", {135'd0, in_ready}, 136'd0);

        // Full load, valid held high, words 0x00..0x11.
        for (int i = 0; i < 18; i++) words[i] = 8'(i);
        exp_sh   = 144'h000102030405060708090A0B0C0D0E0F1011;
        exp_luts = exp_sh[136:1];
        do_load(1'b0, 1'b0, lat, xfers, cens);
        chk("full_cen_count", 136'(cens), 136'd1);
        chk("full_latency", 136'(lat), 136'd19);
        chk("full_xfers", 136'(xfers), 136'd18);
        chk("full_commit_luts", commit_luts, exp_luts);
        chk("full_commit_cc", {135'd0, commit_cc}, 136'd1);
        chk("full_luts", luts_config_out, exp_luts);
        chk("full_cc", {135'd0, config_use_cc}, 136'd1);
        chk("full_done", {135'd0, done}, 136'd1);
        chk("full_busy", {135'd0, busy}, 136'd0);

        // Backpressure: valid alternates starting low.
        do_load(1'b1, 1'b0, lat, xfers, cens);
        chk("bp_cen_count", 136'(cens), 136'd1);
        chk("bp_latency", 136'(lat), 136'd37);
        chk("bp_xfers", 136'(xfers), 136'd18);
        chk("bp_luts", luts_config_out, exp_luts);
        chk("bp_cc", {135'd0, config_use_cc}, 136'd1);
        chk("bp_done", {135'd0, done}, 136'd1);

        // Mid-load reset after 10 words of 0xFF, then a fresh load.
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("midrst_no_cen", {135'd0, cen}, 136'd0);
        end
        chk("midrst_busy", {135'd0, busy}, 136'd1);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_luts", luts_config_out, 136'd0);
        chk("midrst_idle", {134'd0, busy, in_ready}, 136'd0);
        chk("midrst_cen", {135'd0, cen}, 136'd0);
        for (int i = 0; i < 18; i++) words[i] = 8'(8'h80 + 2*i);
        exp_sh   = 144'h80828486888A8C8E90929496989A9C9EA0A2;
        exp_luts = exp_sh[136:1];
        do_load(1'b0, 1'b0, lat, xfers, cens);
        chk("fresh_cen_count", 136'(cens), 136'd1);
        chk("fresh_xfers", 136'(xfers), 136'd18);
        chk("fresh_luts", luts_config_out, exp_luts);
        chk("fresh_cc", {135'd0, config_use_cc}, 136'd0);

        // start pulsed while loading word 5 is ignored.
        for (int i = 0; i < 18; i++) words[i] = 8'(8'h30 + i);
        exp_sh   = 144'h303132333435363738393A3B3C3D3E3F4041;
        exp_luts = exp_sh[136:1];
        do_load(1'b0, 1'b1, lat, xfers, cens);
        chk("startld_cen_count", 136'(cens), 136'd1);
        chk("startld_latency", 136'(lat), 136'd19);
        chk("startld_xfers", 136'(xfers), 136'd18);
        chk("startld_luts", luts_config_out, exp_luts);
        chk("startld_cc", {135'd0, config_use_cc}, 136'd1);

        // Reload from DONE with all ones, then offer an extra word in DONE.
        for (int i = 0; i < 18; i++) words[i] = 8'hFF;
        do_load(1'b0, 1'b0, lat, xfers, cens);
        chk("ones_cen_count", 136'(cens), 136'd1);
        chk("ones_luts", luts_config_out, {136{1'b1}});
        chk("ones_cc", {135'd0, config_use_cc}, 136'd1);
        in_valid = 1'b1; in_data = 8'h00;
        chk("done_in_ready", {135'd0, in_ready}, 136'd0);
        tick();
        tick();
        chk("done_hold_luts", luts_config_out, {136{1'b1}});
        chk("done_hold_cc", {135'd0, config_use_cc}, 136'd1);
        chk("done_level", {135'd0, done}, 136'd1);
        chk("done_no_cen", {135'd0, cen}, 136'd0);
        in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
